// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the dinosaur-runner game controller.
//   game_state_t : 2-bit FSM encoding (IDLE=00, RUN=01, OVER=10)
//   BCD_DIGITS   : number of decimal digits in the score
//   SCORE_W      : score bus width (4 bits per BCD digit)
//   SCORE_MAX    : saturation value of the BCD score
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default visible area of the VGA raster
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } game_state_t;

  localparam int BCD_DIGITS = 4;
  localparam int SCORE_W    = 4 * BCD_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// ---------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter that saturates at 9999 instead of wrapping.
// Ports:
//   CLK      in   system clock
//   RESET_N  in   asynchronous active-low reset (count -> 0000)
//   clr      in   synchronous clear, has priority over inc
//   inc      in   increment by one (ignored once the count is 9999)
//   count    out  16-bit packed BCD value, digit 0 in bits [3:0]
// ---------------------------------------------------------------------------
module bcd_counter4
  import game_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  logic [SCORE_W-1:0] count_inc;
  logic               carry;

  // Ripple the +1 through the digits: a 9 rolls to 0 and passes the carry on,
  // any other digit absorbs it.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (carry) begin
        if (count[4*d +: 4] == 4'd9) begin
          count_inc[4*d +: 4] = 4'd0;
        end else begin
          count_inc[4*d +: 4] = count[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // The saturation check keeps 9999 from rolling over to 0000.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != SCORE_MAX)) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Central game-state controller for the dinosaur runner. Collisions between
// the dinosaur and cactus sprites are latched during the visible frame; all
// state, score and speed changes are committed on the falling edge of vs.
//
// Ports:
//   CLK          in   system clock
//   RESET_N      in   asynchronous active-low reset
//   START        in   start/restart request (level, debounced)
//   vs           in   VGA vertical sync, low during blanking
//   row_addr     in   current VGA row (9 bits)
//   col_addr     in   current VGA column (10 bits)
//   px_dinosaur  in   dinosaur sprite pixel lit
//   px_cactus    in   cactus sprite pixel lit
//   game_status  out  1 while running
//   game_state   out  00 IDLE, 01 RUN, 10 OVER
//   speed        out  scroll speed (4 bits)
//   score        out  4-digit BCD score
//   hit          out  one-cycle pulse on RUN -> OVER
//   hiscore      out  BCD high score
//
// Build option: define GAME_CTRL_HISCORE_EN to keep a high-score register;
// without it hiscore is constant zero.
// ---------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = 6,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 15,
  parameter int POINTS_PER_SPEED = 100,
  parameter int H_ACTIVE         = H_ACTIVE_DEF,
  parameter int V_ACTIVE         = V_ACTIVE_DEF
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               vs,
  input  logic [8:0]         row_addr,
  input  logic [9:0]         col_addr,
  input  logic               px_dinosaur,
  input  logic               px_cactus,
  output logic               game_status,
  output logic [1:0]         game_state,
  output logic [3:0]         speed,
  output logic [SCORE_W-1:0] score,
  output logic               hit,
  output logic [SCORE_W-1:0] hiscore
);

  localparam int FCW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int PCW = (POINTS_PER_SPEED > 1) ? $clog2(POINTS_PER_SPEED) : 1;

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_POINT - 1);
  localparam logic [PCW-1:0] POINT_LAST = PCW'(POINTS_PER_SPEED - 1);
  localparam logic [9:0]     H_LIM      = 10'(H_ACTIVE);
  localparam logic [8:0]     V_LIM      = 9'(V_ACTIVE);
  localparam logic [3:0]     SPD_INIT   = 4'(SPEED_INIT);
  localparam logic [3:0]     SPD_MAX    = 4'(SPEED_MAX);

  game_state_t    state;
  game_state_t    state_nxt;
  logic           vs_d;
  logic           frame_tick;
  logic           visible;
  logic           hit_latch;
  logic           start_pending;
  logic [FCW-1:0] frame_cnt;
  logic [PCW-1:0] point_cnt;

  logic           waiting;
  logic           start_go;
  logic           run_tick;
  logic           go_over;
  logic           frame_adv;
  logic           point_due;
  logic           score_inc;
  logic           speed_step;

  assign frame_tick = vs_d & ~vs;
  assign visible    = (col_addr < H_LIM) & (row_addr < V_LIM) & vs;

  // Frame-level decisions. A latched hit pre-empts the score update of the
  // same frame, and point_cnt only advances while the score can still move.
  assign waiting    = (state == IDLE) | (state == OVER);
  assign start_go   = frame_tick & start_pending & waiting;
  assign run_tick   = frame_tick & (state == RUN);
  assign go_over    = run_tick & hit_latch;
  assign frame_adv  = run_tick & ~hit_latch;
  assign point_due  = frame_adv & (frame_cnt == FRAME_LAST);
  assign score_inc  = point_due & (score != SCORE_MAX);
  assign speed_step = score_inc & (point_cnt == POINT_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_d <= 1'b0;
    end else begin
      vs_d <= vs;
    end
  end

  // The tick clears the latches after they have been used in that cycle.
  // A restart request is only remembered outside of RUN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_latch     <= 1'b0;
      start_pending <= 1'b0;
    end else begin
      if (frame_tick) begin
        hit_latch <= 1'b0;
      end else if (visible && px_dinosaur && px_cactus && (state == RUN)) begin
        hit_latch <= 1'b1;
      end

      if (start_go) begin
        start_pending <= 1'b0;
      end else if (START && waiting) begin
        start_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the unused encoding 11 falls back to IDLE.
  always_comb begin
    state_nxt   = state;
    game_status = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_nxt = RUN;
      end
      RUN: begin
        game_status = 1'b1;
        if (go_over) state_nxt = OVER;
      end
      OVER: begin
        if (start_go) state_nxt = RUN;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign game_state = state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_cnt <= '0;
      point_cnt <= '0;
      speed     <= SPD_INIT;
      hit       <= 1'b0;
    end else begin
      hit <= go_over;

      if (start_go) begin
        frame_cnt <= '0;
      end else if (frame_adv) begin
        frame_cnt <= point_due ? '0 : frame_cnt + 1'b1;
      end

      if (start_go) begin
        point_cnt <= '0;
      end else if (score_inc) begin
        point_cnt <= speed_step ? '0 : point_cnt + 1'b1;
      end

      if (start_go) begin
        speed <= SPD_INIT;
      end else if (speed_step && (speed != SPD_MAX)) begin
        speed <= speed + 4'd1;
      end
    end
  end

  bcd_counter4 u_score (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (start_go),
    .inc     (score_inc),
    .count   (score)
  );

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Packed BCD orders the same way as plain unsigned, so a direct compare
  // is enough. Only reset clears the high score.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hiscore_q <= '0;
    end else if (go_over && (score > hiscore_q)) begin
      hiscore_q <= score;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
// Drives two game_ctrl instances from one stimulus stream: one with default
// parameters and one scoring every frame so the 9999 ceiling is reachable.
// A decimal-integer model of the game rules predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

`ifdef GAME_CTRL_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic       vs = 1'b1;
  logic [8:0] row_addr = '0;
  logic [9:0] col_addr = '0;
  logic       px_dinosaur = 1'b0;
  logic       px_cactus = 1'b0;

  logic        status_w  [2];
  logic [1:0]  state_w   [2];
  logic [3:0]  speed_w   [2];
  logic [15:0] score_w   [2];
  logic        hit_w     [2];
  logic [15:0] hiscore_w [2];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  game_ctrl dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .vs          (vs),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .px_dinosaur (px_dinosaur),
    .px_cactus   (px_cactus),
    .game_status (status_w[0]),
    .game_state  (state_w[0]),
    .speed       (speed_w[0]),
    .score       (score_w[0]),
    .hit         (hit_w[0]),
    .hiscore     (hiscore_w[0])
  );

  game_ctrl #(.FRAMES_PER_POINT(1)) dut_fast (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .vs          (vs),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .px_dinosaur (px_dinosaur),
    .px_cactus   (px_cactus),
    .game_status (status_w[1]),
    .game_state  (state_w[1]),
    .speed       (speed_w[1]),
    .score       (score_w[1]),
    .hit         (hit_w[1]),
    .hiscore     (hiscore_w[1])
  );

  // Game model: mode 0 idle, 1 running, 2 over; score kept as a decimal int.
  typedef struct packed {
    int mode;
    int score;
    int speed;
    int fcnt;
    int pcnt;
    int hi;
    bit hl;
    bit pend;
    bit vsd;
    bit hitp;
  } mdl_t;

  mdl_t m [2];
  int   fpp [2] = '{6, 1};

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic mdl_t model_step(input mdl_t c, input int fp);
    mdl_t n;
    bit   tick;
    bit   seen;
    bit   waiting;
    n       = c;
    tick    = c.vsd && !vs;
    seen    = (int'(col_addr) < 640) && (int'(row_addr) < 480) && vs;
    waiting = (c.mode != 1);
    n.hitp  = 1'b0;
    if (tick && waiting && c.pend) begin
      n.mode  = 1;
      n.score = 0;
      n.speed = 1;
      n.fcnt  = 0;
      n.pcnt  = 0;
    end else if (tick && c.mode == 1) begin
      if (c.hl) begin
        n.mode = 2;
        n.hitp = 1'b1;
        if (HS_EN && c.score > c.hi) n.hi = c.score;
      end else if (c.fcnt == fp - 1) begin
        n.fcnt = 0;
        if (c.score < 9999) begin
          n.score = c.score + 1;
          if (c.pcnt == 99) begin
            n.pcnt = 0;
            if (c.speed < 15) n.speed = c.speed + 1;
          end else begin
            n.pcnt = c.pcnt + 1;
          end
        end
      end else begin
        n.fcnt = c.fcnt + 1;
      end
    end
    n.hl   = tick ? 1'b0 : (c.hl || (seen && px_dinosaur && px_cactus && c.mode == 1));
    n.pend = (tick && waiting && c.pend) ? 1'b0 : (c.pend || (START && waiting));
    n.vsd  = vs;
    return n;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 2; i++) begin
        m[i]       = '0;
        m[i].speed = 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) m[i] = model_step(m[i], fpp[i]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Outputs are all registered, so the falling edge is a stable sample point.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("state[%0d]", i), 32'(state_w[i]), 32'(m[i].mode));
      checkOutput($sformatf("status[%0d]", i), 32'(status_w[i]), 32'(m[i].mode == 1));
      checkOutput($sformatf("speed[%0d]", i), 32'(speed_w[i]), 32'(m[i].speed));
      checkOutput($sformatf("score[%0d]", i), 32'(score_w[i]), 32'(to_bcd(m[i].score)));
      checkOutput($sformatf("hit[%0d]", i), 32'(hit_w[i]), 32'(m[i].hitp));
      checkOutput($sformatf("hiscore[%0d]", i), 32'(hiscore_w[i]), 32'(to_bcd(m[i].hi)));
    end
  end

  // One frame: nv visible cycles then nlow blanking cycles. Optional START
  // pulse on the first visible cycle, optional forced overlap on the last.
  task automatic applyStimulus(input int nv, input int nlow, input bit do_start,
                               input bit do_coll, input int crow, input int ccol,
                               input bit noise);
    for (int i = 0; i < nv; i++) begin
      @(negedge CLK);
      vs          = 1'b1;
      row_addr    = 9'($urandom_range(0, 511));
      col_addr    = 10'($urandom_range(0, 1023));
      px_dinosaur = 1'b0;
      px_cactus   = 1'b0;
      START       = 1'b0;
      if (noise) begin
        px_dinosaur = 1'($urandom_range(0, 1));
        px_cactus   = 1'($urandom_range(0, 1));
        if (px_dinosaur && px_cactus) col_addr = 10'($urandom_range(640, 1023));
        START = ($urandom_range(0, 7) == 0);
      end
      if (do_start && i == 0) START = 1'b1;
      if (do_coll && i == nv - 1) begin
        row_addr    = 9'(crow);
        col_addr    = 10'(ccol);
        px_dinosaur = 1'b1;
        px_cactus   = 1'b1;
      end
    end
    for (int i = 0; i < nlow; i++) begin
      @(negedge CLK);
      vs          = 1'b0;
      START       = 1'b0;
      px_dinosaur = 1'($urandom_range(0, 1));
      px_cactus   = 1'($urandom_range(0, 1));
      row_addr    = 9'($urandom_range(0, 479));
      col_addr    = 10'($urandom_range(0, 639));
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] reset");
    repeat (3) @(negedge CLK);
    checkOutput("reset_state", 32'(state_w[0]), 32'd0);
    checkOutput("reset_speed", 32'(speed_w[0]), 32'd1);
    checkOutput("reset_score", 32'(score_w[0]), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    $display("[TB] idle frames");
    repeat (3) applyStimulus(4, 2, 1'b0, 1'b0, 0, 0, 1'b0);
    checkOutput("idle_state", 32'(state_w[0]), 32'd0);
    checkOutput("idle_status", 32'(status_w[0]), 32'd0);
    checkOutput("idle_speed", 32'(speed_w[0]), 32'd1);

    $display("[TB] start");
    applyStimulus(6, 1, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("status_on_tick", 32'(status_w[0]), 32'd0);
    @(negedge CLK);
    checkOutput("status_after_tick", 32'(status_w[0]), 32'd1);
    repeat (12) applyStimulus(5, 2, 1'b0, 1'b0, 0, 0, 1'b1);
    checkOutput("score_12_frames", 32'(score_w[0]), 32'h0002);
    checkOutput("fast_score_12_frames", 32'(score_w[1]), 32'h0012);

    $display("[TB] collisions");
    applyStimulus(5, 2, 1'b0, 1'b1, 300, 700, 1'b1);
    checkOutput("offscreen_overlap_state", 32'(state_w[0]), 32'd1);
    applyStimulus(5, 1, 1'b0, 1'b1, 300, 100, 1'b1);
    checkOutput("hit_before_tick", 32'(hit_w[0]), 32'd0);
    @(negedge CLK);
    checkOutput("over_state", 32'(state_w[0]), 32'd2);
    checkOutput("hit_pulse", 32'(hit_w[0]), 32'd1);
    checkOutput("over_score", 32'(score_w[0]), 32'h0002);
    @(negedge CLK);
    checkOutput("hit_single_cycle", 32'(hit_w[0]), 32'd0);

    $display("[TB] game to 42");
    applyStimulus(4, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("restart_score", 32'(score_w[0]), 32'h0);
    repeat (252) applyStimulus(3, 2, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus(3, 2, 1'b0, 1'b1, 200, 50, 1'b1);
    checkOutput("game2_state", 32'(state_w[0]), 32'd2);
    checkOutput("game2_score", 32'(score_w[0]), 32'h0042);

    $display("[TB] game to 17 with hit/score tie");
    applyStimulus(4, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    checkOutput("restart2_score", 32'(score_w[0]), 32'h0);
    checkOutput("restart2_speed", 32'(speed_w[0]), 32'd1);
    repeat (107) applyStimulus(3, 2, 1'b0, 1'b0, 0, 0, 1'b1);
    applyStimulus(3, 2, 1'b0, 1'b1, 479, 639, 1'b1);
    checkOutput("tie_state", 32'(state_w[0]), 32'd2);
    checkOutput("tie_score", 32'(score_w[0]), 32'h0017);
    checkOutput("hiscore_kept", 32'(hiscore_w[0]), HS_EN ? 32'h0042 : 32'h0);

    $display("[TB] long run");
    applyStimulus(4, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (99) applyStimulus(1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    checkOutput("fast_speed_99", 32'(speed_w[1]), 32'd1);
    checkOutput("fast_score_99", 32'(score_w[1]), 32'h0099);
    applyStimulus(1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    checkOutput("fast_speed_100", 32'(speed_w[1]), 32'd2);
    repeat (9911) applyStimulus(1, 1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge CLK);
    checkOutput("fast_score_sat", 32'(score_w[1]), 32'h9999);
    checkOutput("fast_speed_sat", 32'(speed_w[1]), 32'd15);
    checkOutput("long_score", 32'(score_w[0]), 32'h1668);
    checkOutput("long_speed_sat", 32'(speed_w[0]), 32'd15);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Central game-state controller for the dinosaur runner. It sits downstream of the sprite pixel generators (dinosaur, cactus) and upstream of every module that consumes game_status and speed.
- Detects per-pixel dinosaur/cactus overlap during the visible frame and commits state changes only in the vertical blanking interval.
- Runs the IDLE/RUN/OVER state machine, the BCD score counter and the speed ramp.

Parameters:
- FRAMES_PER_POINT, 6, frames in RUN per +1 score.
- SPEED_INIT, 1, speed value after reset or restart.
- SPEED_MAX, 15, speed saturation value (4-bit).
- POINTS_PER_SPEED, 100, score increments between speed steps.
- H_ACTIVE, 640, columns counted as visible.
- V_ACTIVE, 480, rows counted as visible.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  start/restart request, level, active-high, already debounced.
- vs  in  1  VGA vertical sync; low marks the blanking period.
- row_addr  in  9  current VGA row.
- col_addr  in  10  current VGA column.
- px_dinosaur  in  1  dinosaur sprite pixel is lit.
- px_cactus  in  1  cactus pixel is lit.
- game_status  out  1  1 while in RUN; drives the jump, ground and cactus blocks.
- game_state  out  2  00 IDLE, 01 RUN, 10 OVER.
- speed  out  4  current scroll speed.
- score  out  16  4-digit BCD score.
- hit  out  1  one-cycle pulse on the transition RUN->OVER.
- hiscore  out  16  BCD high score (see Optional Feature).

Behaviour:
- Reset values (async, RESET_N=0): game_state=IDLE, game_status=0, speed=SPEED_INIT, score=0, hit=0, hiscore=0, all internal latches cleared.
- vs is registered once (vs_d).
- frame_tick = vs_d & ~vs: a one-cycle pulse on the falling edge of vs. All state, score and speed updates happen only on frame_tick.
- visible = (col_addr < H_ACTIVE) & (row_addr < V_ACTIVE) & vs.
- hit_latch:
  - Set on any cycle with visible & px_dinosaur & px_cactus while in RUN.
  - Cleared on frame_tick, after it has been evaluated in that same cycle.
- start_pending:
  - Set when START=1 and state is IDLE or OVER.
  - Cleared on the frame_tick that consumes it.
  - START while in RUN is ignored.
- IDLE: game_status=0. On frame_tick with start_pending, go to RUN; score=0, speed=SPEED_INIT, frame_cnt=0.
- RUN: game_status=1. On frame_tick:
  - If hit_latch: go to OVER and pulse hit for 1 cycle. No score increment in that frame; a hit always wins over a simultaneous score increment.
  - Else: frame_cnt+1. When frame_cnt reaches FRAMES_PER_POINT-1, wrap frame_cnt to 0 and increment score.
- Score arithmetic:
  - BCD increment with per-digit carry.
  - Saturates at 9999; no wrap to 0000.
- Speed ramp:
  - Each score increment also advances point_cnt.
  - When point_cnt reaches POINTS_PER_SPEED-1, wrap point_cnt and increment speed. Speed saturates at SPEED_MAX.
- OVER: game_status=0; score and speed held. On frame_tick with start_pending, go to RUN with score, speed, frame_cnt and point_cnt reinitialised as in IDLE->RUN.
- Latency:
  - A START asserted mid-frame takes effect at the next frame_tick; game_status rises on the cycle after that tick.
  - A collision in frame N moves the FSM to OVER at the blanking that ends frame N.
- Reset mid-frame: all latches cleared immediately; a pending start is lost.
- Illegal state 11 recovers to IDLE on the next cycle.

Optional Feature:
- Macro GAME_CTRL_HISCORE_EN.
- Defined:
  - hiscore updates on the RUN->OVER transition if score > hiscore, compared as BCD, which is equivalent to unsigned comparison.
  - hiscore is cleared only by RESET_N, not by restart.
- Undefined: hiscore is tied to 16'h0000 and no register is inferred.

Decomposition:
- Package game_pkg holds:
  - the state encoding constants IDLE/RUN/OVER (2-bit);
  - BCD_DIGITS=4 and the score width;
  - the default H_ACTIVE/V_ACTIVE.
- One sub-module, bcd_counter4: synchronous clear, increment enable, saturates at 9999, exposes the 16-bit value. It is instantiated once for score. The hiscore comparison stays in game_ctrl.

Test Plan:
- Reset then idle frames: RESET_N low then high, 3 frames with no START -> game_state=00, game_status=0, score=0000, speed=1.
- Start: pulse START mid-frame -> game_status=1 exactly 1 cycle after the next vs falling edge; after 12 clean frames score=0002.
- Collision: in RUN, assert px_dinosaur=px_cactus=1 for 1 cycle at row 300, col 100 -> at the next frame_tick state=10, hit pulses 1 cycle, score frozen. The same overlap at col 700 (not visible) -> no transition.
- Hit/score tie: collision in the frame where frame_cnt=5 -> state=OVER, score not incremented.
- Saturation: force score to 9998 in RUN and run 12 frames -> score=9999 and holds; speed after 100 points -> 2; speed never exceeds 15.
- Restart with GAME_CTRL_HISCORE_EN defined: end a game at score 0042, restart, end at 0017 -> hiscore=0042, and after restart score=0000, speed=1.
